// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants from the ALU control stage and
// the state encoding of the iterative ALU sequencer.
package alu_pkg;

    localparam int XLEN = 32;
    localparam int SHAMT_W = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SRA = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    function automatic logic isShiftOp(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations. Shift opcodes and unknown codes give 0 here;
// shifts are sequenced by iter_alu.
module alu_comb
    import alu_pkg::*;
(
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle ops finish the cycle after acceptance, shifts
// advance one bit per cycle; result/zero update only when done_o pulses.
module iter_alu
    import alu_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [3:0]      ALU_Ctrl_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            busy_o,
    output logic            done_o
);

    alu_state_t           r_state;
    alu_state_t           w_nextState;
    logic [XLEN-1:0]      r_shiftReg;
    logic [XLEN-1:0]      r_result;
    logic                 r_zero;
    logic [SHAMT_W-1:0]   r_count;
    logic                 r_isSra;
    logic [XLEN-1:0]      w_combResult;
    logic [XLEN-1:0]      w_shifted;
    logic [SHAMT_W-1:0]   w_shamt;
    logic                 w_accept;
    logic                 w_isShift;

    alu_comb u_alu_comb (
        .op     (ALU_Ctrl_i),
        .a      (src1_i),
        .b      (src2_i),
        .result (w_combResult)
    );

    assign w_shamt   = src2_i[SHAMT_W-1:0];
    assign w_isShift = isShiftOp(ALU_Ctrl_i);
    assign w_accept  = start_i && (r_state != SHIFT);
    assign w_shifted = r_isSra ? {r_shiftReg[XLEN-1], r_shiftReg[XLEN-1:1]}
                               : {r_shiftReg[XLEN-2:0], 1'b0};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (!start_i) begin
                    w_nextState = IDLE;
                end else if (w_isShift && (w_shamt != '0)) begin
                    w_nextState = SHIFT;
                end else begin
                    w_nextState = DONE;
                end
            end
            SHIFT: begin
                if (r_count == SHAMT_W'(1)) begin
                    w_nextState = DONE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (r_state)
            SHIFT:   busy_o = 1'b1;
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    // The final shift step writes straight to the result, so partial values stay internal.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_shiftReg <= '0;
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_count    <= '0;
            r_isSra    <= 1'b0;
        end else if (w_accept) begin
            if (!w_isShift) begin
                r_result <= w_combResult;
                r_zero   <= (w_combResult == '0);
            end else if (w_shamt == '0) begin
                r_result <= src1_i;
                r_zero   <= (src1_i == '0);
            end else begin
                r_shiftReg <= src1_i;
                r_count    <= w_shamt;
                r_isSra    <= (ALU_Ctrl_i == ALU_SRA);
            end
        end else if (r_state == SHIFT) begin
            r_shiftReg <= w_shifted;
            r_count    <= r_count - SHAMT_W'(1);
            if (r_count == SHAMT_W'(1)) begin
                r_result <= w_shifted;
                r_zero   <= (w_shifted == '0);
            end
        end
    end

    assign result_o = r_result;
    assign zero_o   = r_zero;

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk_i  input  1  rising-edge clock for all state.
REQ-003 rst_i  input  1  asynchronous active-low reset; 0 clears all state immediately.
REQ-004 start_i  input  1  request; accepted only when busy_o=0.
REQ-005 ALU_Ctrl_i  input  4  operation code from the ALU control stage.
REQ-006 src1_i  input  32  operand A.
REQ-007 src2_i  input  32  operand B; for shifts, shamt = src2_i[4:0].
REQ-008 result_o  output  32  registered result, held until the next done_o.
REQ-009 zero_o  output  1  registered; 1 iff result_o == 0.
REQ-010 busy_o  output  1  high while an iterative shift is in progress.
REQ-011 done_o  output  1  one-cycle pulse: result_o/zero_o are valid and updated.

Function
REQ-012 Opcodes SHALL be: 0010 add, 0110 sub, 0000 and, 0001 or, 0100 xor, 0111 slt (signed, result 0/1), 0101 sll, 0011 sra (arithmetic right).
REQ-013 Any other opcode SHALL complete as a single-cycle op with result 0.
REQ-014 Add/sub SHALL wrap modulo 2^32; no overflow flag.
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE.
- IDLE/DONE + accepted start, non-shift op -> DONE.
- Shift op with shamt=0 -> DONE with result = src1.
- Shift op with shamt=n>0 -> SHIFT.
- SHIFT with remaining count 1 -> DONE.
- DONE without start -> IDLE.
REQ-016 Operands and opcode SHALL be captured on the accepting edge (cycle T); later input changes SHALL NOT affect the operation.
REQ-017 Non-shift ops and zero-shamt shifts SHALL assert done_o in cycle T+1.
REQ-018 Shifts with n>0 SHALL shift exactly one bit per cycle:
- busy_o high in cycles T+1..T+n;
- done_o in cycle T+n+1.
REQ-019 sra SHALL replicate bit 31 of the captured operand; sll SHALL fill with 0.
REQ-020 busy_o SHALL be low in the DONE state, so a start is accepted in the done_o cycle (back-to-back; throughput 1 op/cycle for non-shift ops).
REQ-021 start_i while busy_o=1 SHALL be ignored, not queued.
REQ-022 result_o and zero_o SHALL change only in the cycle done_o rises; intermediate shift values SHALL NOT be visible on result_o.

Reset
REQ-023 On rst_i=0 the block SHALL asynchronously force:
- state IDLE;
- result_o = 0, zero_o = 1;
- busy_o = 0, done_o = 0;
- shift counter = 0.
REQ-024 Reset asserted mid-shift SHALL abort the operation without producing done_o.
REQ-025 After release, the first rising edge SHALL be able to accept start_i.

Structure
REQ-026 The opcode constants (REQ-012) and the FSM state encoding SHALL live in the shared package alu_pkg, also used by the ALU control stage.
REQ-027 Single-cycle ops (add, sub, and, or, xor, slt) SHALL be one combinational sub-module, alu_comb (inputs: op, a, b; output: 32-bit result).
REQ-028 The shift datapath, counter and FSM SHALL remain in iter_alu.

Verification
REQ-029 Bench SHALL cover the following scenarios:
- add 0x7FFFFFFF + 1 -> done_o at T+1, result_o 0x80000000, zero_o 0.
- sub 5 - 5, then back-to-back slt -1 < 1 on the done_o cycle -> results 0 (zero_o 1), then 1 on consecutive cycles.
- sra 0x80000000 by 4 -> busy_o for 4 cycles, done_o at T+5, result_o 0xF8000000.
- sll 0x1 by 31, with start_i pulsed while busy_o=1 -> second start ignored; result_o 0x80000000 at T+32.
- Shift with shamt=0 and opcode 1111 -> each done at T+1, results src1 and 0 respectively.
- Reset asserted mid-sll -> outputs at reset values immediately; no done_o; next add completes normally.
